// File: rtl/toggle_monitor.sv
// +----------------------------------------------------------------------------+
// | toggle_monitor: edge pulses, saturating toggle count, period and stall FSM |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module toggle_monitor #(
    parameter int CNT_W   = 8,
    parameter int PER_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tin,
    input  logic             clr,
    output logic             rise,
    output logic             fall,
    output logic             edge_p,
    output logic [CNT_W-1:0] tog_cnt,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] GAP_LAST = PER_W'(TIMEOUT - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic             tin_d;
    logic [PER_W-1:0] gap;
    logic [PER_W-1:0] nxt_gap;
    logic [PER_W-1:0] nxt_period;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_vld;
    logic             nxt_timeout;
    logic             detect;

    assign detect = tin ^ tin_d;
    assign state  = cur_state;

    always_comb begin
        nxt_state   = cur_state;
        nxt_gap     = gap;
        nxt_period  = period;
        nxt_cnt     = tog_cnt;
        nxt_vld     = 1'b0;
        nxt_timeout = timeout;

        if (clr) begin
            // clear wins over a coincident edge: it neither counts nor starts MEASURE
            nxt_state   = IDLE;
            nxt_gap     = '0;
            nxt_period  = '0;
            nxt_cnt     = '0;
            nxt_timeout = 1'b0;
        end else begin
            if (detect && (tog_cnt != CNT_MAX)) begin
                nxt_cnt = tog_cnt + 1'b1;
            end
            case (cur_state)
                IDLE: begin
                    if (detect) begin
                        nxt_state = MEASURE;
                        nxt_gap   = '0;
                    end
                end
                MEASURE: begin
                    if (detect) begin
                        nxt_period = gap + 1'b1;
                        nxt_vld    = 1'b1;
                        nxt_gap    = '0;
                    end else begin
                        nxt_gap = gap + 1'b1;
                        if (gap == GAP_LAST) begin
                            nxt_state   = STALL;
                            nxt_timeout = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (detect) begin
                        nxt_state   = MEASURE;
                        nxt_timeout = 1'b0;
                        nxt_gap     = '0;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state  <= IDLE;
            tin_d      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_p     <= 1'b0;
            tog_cnt    <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
            gap        <= '0;
        end else begin
            cur_state  <= nxt_state;
            tin_d      <= tin;
            rise       <= tin & ~tin_d;
            fall       <= ~tin & tin_d;
            edge_p     <= detect;
            tog_cnt    <= nxt_cnt;
            period     <= nxt_period;
            period_vld <= nxt_vld;
            timeout    <= nxt_timeout;
            gap        <= nxt_gap;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_toggle_monitor.sv
// Self-checking bench for toggle_monitor: vector table, directed corner sequences,
// and random stimulus against a cycle-stamp reference model.
`default_nettype none

module tb_toggle_monitor;

    localparam int CNT_W   = 4;
    localparam int PER_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             tin;
    logic             clr;
    logic             rise;
    logic             fall;
    logic             edge_p;
    logic [CNT_W-1:0] tog_cnt;
    logic [PER_W-1:0] period;
    logic             period_vld;
    logic             timeout;
    logic [1:0]       state;

    toggle_monitor #(.CNT_W(CNT_W), .PER_W(PER_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tin(tin), .clr(clr),
        .rise(rise), .fall(fall), .edge_p(edge_p), .tog_cnt(tog_cnt),
        .period(period), .period_vld(period_vld), .timeout(timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: edges are stamped with the cycle number they were sampled on
    int   m_n = 0;
    logic m_prev = 1'b0;
    int   m_cnt = 0, m_period = 0, m_last = -1;
    bit   m_stall = 1'b0;
    int   e_rise, e_fall, e_edge, e_vld, e_state;

    typedef struct {
        logic t, r, c;
        int   rise, fall, edg, cnt, st;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, m_n, act, exp);
        end
    endtask

    task automatic model_step(input logic t, input logic r, input logic c);
        bit det;
        det   = t ^ m_prev;
        e_vld = 0;
        if (!r) begin
            e_rise = 0; e_fall = 0; e_edge = 0;
            m_prev = 1'b0; m_cnt = 0; m_period = 0; m_last = -1; m_stall = 1'b0;
        end else begin
            e_rise = int'(t & ~m_prev);
            e_fall = int'(~t & m_prev);
            e_edge = int'(det);
            m_prev = t;
            if (c) begin
                m_cnt = 0; m_period = 0; m_last = -1; m_stall = 1'b0;
            end else if (det) begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (m_last >= 0 && !m_stall) begin
                    m_period = m_n - m_last;
                    e_vld    = 1;
                end
                m_last  = m_n;
                m_stall = 1'b0;
            end else if (m_last >= 0 && (m_n - m_last) >= TIMEOUT) begin
                m_stall = 1'b1;
            end
        end
        e_state = (m_last < 0) ? 0 : (m_stall ? 2 : 1);
        m_n++;
    endtask

    task automatic check_model();
        chk("rise", int'(rise), e_rise);
        chk("fall", int'(fall), e_fall);
        chk("edge_p", int'(edge_p), e_edge);
        chk("tog_cnt", int'(tog_cnt), m_cnt);
        chk("period", int'(period), m_period);
        chk("period_vld", int'(period_vld), e_vld);
        chk("timeout", int'(timeout), int'(m_stall));
        chk("state", int'(state), e_state);
    endtask

    // drive at the falling edge, update model at the rising edge, sample 1ns later
    task automatic cyc(input logic t, input logic r, input logic c);
        tin = t; rst = r; clr = c;
        @(posedge clk);
        model_step(t, r, c);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[8];
    int   vld_cnt, edge_cnt, mode;

    initial begin
        tin = 1'b0; rst = 1'b0; clr = 1'b0;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1, 0, 1, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 1, 1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 1};
        @(negedge clk);

        // reset hold with tin toggling, release, then clr coincident with an edge
        foreach (vecs[i]) begin
            cyc(vecs[i].t, vecs[i].r, vecs[i].c);
            chk("tbl_rise", int'(rise), vecs[i].rise);
            chk("tbl_fall", int'(fall), vecs[i].fall);
            chk("tbl_edge", int'(edge_p), vecs[i].edg);
            chk("tbl_cnt", int'(tog_cnt), vecs[i].cnt);
            chk("tbl_state", int'(state), vecs[i].st);
        end

        // toggle every 4 cycles, 5 edges
        do_reset();
        vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(((i / 4) % 2) == 0, 1'b1, 1'b0);
            if (period_vld) begin
                vld_cnt++;
                chk("sp4_period", int'(period), 4);
            end
        end
        chk("sp4_cnt", int'(tog_cnt), 5);
        chk("sp4_vld_count", vld_cnt, 4);

        // timeout boundary
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("to_vld16", int'(period_vld), 1);
        chk("to_period16", int'(period), TIMEOUT);
        chk("to_no_timeout", int'(timeout), 0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("to_pre_stall", int'(timeout), 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("to_stall", int'(timeout), 1);
        chk("to_stall_state", int'(state), 2);
        chk("to_stall_period", int'(period), TIMEOUT);
        cyc(1'b1, 1'b1, 1'b0);
        chk("to_resume_timeout", int'(timeout), 0);
        chk("to_resume_state", int'(state), 1);
        chk("to_resume_vld", int'(period_vld), 0);

        // toggle every cycle, saturating counter
        do_reset();
        vld_cnt = 0; edge_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2) == 0, 1'b1, 1'b0);
            if (edge_p) edge_cnt++;
            if (period_vld) begin
                vld_cnt++;
                chk("fast_period", int'(period), 1);
            end
        end
        chk("fast_edges", edge_cnt, 20);
        chk("fast_vlds", vld_cnt, 19);
        chk("fast_sat", int'(tog_cnt), CMAX);

        // reset mid-measurement with tin held high across release
        do_reset();
        for (int i = 0; i < 31; i++) cyc(((i / 5) % 2) == 0, 1'b1, 1'b0);
        chk("mid_cnt", int'(tog_cnt), 7);
        chk("mid_period", int'(period), 5);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_rst_cnt", int'(tog_cnt), 0);
        chk("mid_rst_state", int'(state), 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mid_rel_rise", int'(rise), 1);
        chk("mid_rel_cnt", int'(tog_cnt), 1);

        // random traffic with varying toggle density
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            logic t;
            if (i % 200 == 0) mode = int'($urandom_range(0, 2));
            t = tin;
            case (mode)
                0: if ($urandom_range(0, 1) == 0) t = ~tin;
                1: if ($urandom_range(0, 7) == 0) t = ~tin;
                default: if ($urandom_range(0, 29) == 0) t = ~tin;
            endcase
            cyc(t, $urandom_range(0, 299) != 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
